// File: rtl/registrador_piso_if.sv
// ---------------------------------------------------------------------------
// registrador_piso_if
//   Handshake and serial-output bundle for the registrador_piso PISO shifter.
//
//   Signals:
//     data_in    [WIDTH-1:0]  parallel word from upstream
//     valid                   upstream has a word on data_in
//     ready                   shifter can accept a word this cycle
//     serial_out              serial data bit
//     busy                    high while bits are being shifted
//     done                    one-cycle pulse after the last bit
//
//   Modports:
//     master : upstream / bench side (drives data_in, valid)
//     slave  : shifter side (drives ready, serial_out, busy, done)
// ---------------------------------------------------------------------------
interface registrador_piso_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             ready;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output valid,
        input  ready,
        input  serial_out,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  valid,
        output ready,
        output serial_out,
        output busy,
        output done
    );
endinterface

// File: rtl/registrador_piso.sv
// ---------------------------------------------------------------------------
// registrador_piso
//   Parallel-in / serial-out shift register. A WIDTH-bit word is accepted on
//   a valid/ready handshake while IDLE, shifted out one bit per clock during
//   SHIFT, and followed by a single DONE cycle that pulses 'done'.
//
//   Parameters:
//     WIDTH      bits per word, legal range 2..32
//     LSB_FIRST  1: bit 0 leaves first; 0: bit WIDTH-1 leaves first
//
//   Ports:
//     clock   system clock, rising-edge active
//     reset   asynchronous, active-high; forces IDLE and reset outputs
//     bus     registrador_piso_if.slave (data_in, valid -> ready,
//             serial_out, busy, done)
//
//   All outputs are decoded from registered state only (Moore), so there is
//   no combinational path from valid or data_in to any output.
// ---------------------------------------------------------------------------
module registrador_piso #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    registrador_piso_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Encoding 2'b11 is unused; it is recovered to IDLE on the next edge.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic ready;
    logic busy;
    logic done;
    logic serial_out;

    // Bit currently presented at the output end of the shift register.
    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        if (LSB_FIRST) begin
            return v[0];
        end else begin
            return v[WIDTH-1];
        end
    endfunction

    // Move every bit one place toward the output end; the vacated bit at the
    // far end is zero-filled so a drained register reads as all zeros.
    function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
        if (LSB_FIRST) begin
            return {1'b0, v[WIDTH-1:1]};
        end else begin
            return {v[WIDTH-2:0], 1'b0};
        end
    endfunction

    // ---- state register ---------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---- next-state and Moore output decode -------------------------------
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ready      = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        serial_out = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.valid) begin
                    shift_d = bus.data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                ready      = 1'b0;
                busy       = 1'b1;
                serial_out = out_bit(shift_q);
                shift_d    = shift_toward_out(shift_q);
                // The counter holds on the last bit instead of wrapping, so
                // it never returns to zero inside a word.
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                ready   = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                // Outputs stay at their reset values; scrub the datapath too.
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.ready      = ready;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.serial_out = serial_out;

endmodule

// File: tb/tb_registrador_piso.sv
module tb_registrador_piso;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst = 1'b1;
    logic [7:0] d8  = '0;
    logic       v8  = 1'b0;
    logic [1:0] d2  = '0;
    logic       v2  = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Expected serial bits, in transmission order, one queue per DUT.
    bit qa[$];
    bit qb[$];
    bit qc[$];

    registrador_piso_if #(.WIDTH(8)) ifa ();
    registrador_piso_if #(.WIDTH(8)) ifb ();
    registrador_piso_if #(.WIDTH(2)) ifc ();

    assign ifa.data_in = d8;
    assign ifa.valid   = v8;
    assign ifb.data_in = d8;
    assign ifb.valid   = v8;
    assign ifc.data_in = d2;
    assign ifc.valid   = v2;

    registrador_piso #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
        .clock (clock),
        .reset (rst),
        .bus   (ifa)
    );

    registrador_piso #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
        .clock (clock),
        .reset (rst),
        .bus   (ifb)
    );

    registrador_piso #(.WIDTH(2), .LSB_FIRST(1'b1)) dut_c (
        .clock (clock),
        .reset (rst),
        .bus   (ifc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Status of both 8-bit DUTs against expected ready/busy/done.
    task automatic st8(input string tag, input logic r, input logic b, input logic d);
        check({tag, "_a_ready"}, 32'(ifa.ready), 32'(r));
        check({tag, "_a_busy"},  32'(ifa.busy),  32'(b));
        check({tag, "_a_done"},  32'(ifa.done),  32'(d));
        check({tag, "_b_ready"}, 32'(ifb.ready), 32'(r));
        check({tag, "_b_busy"},  32'(ifb.busy),  32'(b));
        check({tag, "_b_done"},  32'(ifb.done),  32'(d));
    endtask

    task automatic st2(input string tag, input logic r, input logic b, input logic d);
        check({tag, "_c_ready"}, 32'(ifc.ready), 32'(r));
        check({tag, "_c_busy"},  32'(ifc.busy),  32'(b));
        check({tag, "_c_done"},  32'(ifc.done),  32'(d));
    endtask

    // Called at a negedge with the 8-bit DUTs idle; accepts on the next edge.
    task automatic send8(input logic [7:0] w, input bit hold);
        d8 = w;
        v8 = 1'b1;
        st8("pre_accept", 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        for (int k = 0; k < 8; k++) begin
            qa.push_back(w[k]);
            qb.push_back(w[7 - k]);
        end
        #1;
        if (!hold) v8 = 1'b0;
    endtask

    // Eight SHIFT cycles, one DONE cycle, then ready again.
    task automatic tail8();
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            st8("shift", 1'b0, 1'b1, 1'b0);
        end
        @(negedge clock);
        st8("done", 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        st8("ready_back", 1'b1, 1'b0, 1'b0);
    endtask

    // Serial scoreboards: pop an expected bit on every busy cycle; outside
    // SHIFT the line must sit at zero.
    always @(negedge clock) begin
        if (ifa.busy === 1'b1) begin
            if (qa.size() == 0) check("a_unexpected_busy", 32'(ifa.busy), 32'd0);
            else                check("a_bit", 32'(ifa.serial_out), 32'(qa.pop_front()));
        end else begin
            check("a_line_idle", 32'(ifa.serial_out), 32'd0);
        end
    end

    always @(negedge clock) begin
        if (ifb.busy === 1'b1) begin
            if (qb.size() == 0) check("b_unexpected_busy", 32'(ifb.busy), 32'd0);
            else                check("b_bit", 32'(ifb.serial_out), 32'(qb.pop_front()));
        end else begin
            check("b_line_idle", 32'(ifb.serial_out), 32'd0);
        end
    end

    always @(negedge clock) begin
        if (ifc.busy === 1'b1) begin
            if (qc.size() == 0) check("c_unexpected_busy", 32'(ifc.busy), 32'd0);
            else                check("c_bit", 32'(ifc.serial_out), 32'(qc.pop_front()));
        end else begin
            check("c_line_idle", 32'(ifc.serial_out), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-up reset: outputs must already be at reset values.
        #1;
        st8("por", 1'b1, 1'b0, 1'b0);
        st2("por", 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clock);
            st8("idle", 1'b1, 1'b0, 1'b0);
            st2("idle", 1'b1, 1'b0, 1'b0);
        end

        // Single words; A is LSB-first, B is MSB-first.
        send8(8'hA5, 1'b0);
        tail8();
        send8(8'h81, 1'b0);
        tail8();
        send8(8'h0F, 1'b0);
        tail8();

        // Back-to-back with valid held high; data_in scrambled while busy.
        send8(8'h3C, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock);
            if (i <= 8) st8("b2b_shift", 1'b0, 1'b1, 1'b0);
            else        st8("b2b_done",  1'b0, 1'b0, 1'b1);
            d8 = (i < 9) ? 8'($urandom) : 8'hFF;
        end
        @(negedge clock);
        send8(8'hFF, 1'b0);
        tail8();

        // Reset in the 4th SHIFT cycle, between clock edges.
        send8(8'hFF, 1'b0);
        repeat (3) @(posedge clock);
        #2;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        st8("rst_async", 1'b1, 1'b0, 1'b0);
        check("rst_async_a_line", 32'(ifa.serial_out), 32'd0);
        check("rst_async_b_line", 32'(ifb.serial_out), 32'd0);
        // valid during reset must not be captured.
        v8 = 1'b1;
        d8 = 8'h55;
        repeat (3) begin
            @(negedge clock);
            st8("rst_hold", 1'b1, 1'b0, 1'b0);
        end
        @(negedge clock);
        v8  = 1'b0;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clock);
            st8("post_rst_idle", 1'b1, 1'b0, 1'b0);
        end
        send8(8'h01, 1'b0);
        tail8();

        // Minimum width, LSB-first: bits 0 then 1.
        @(negedge clock);
        d2 = 2'b10;
        v2 = 1'b1;
        st2("w2_pre", 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        qc.push_back(1'b0);
        qc.push_back(1'b1);
        #1;
        v2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            st2("w2_shift", 1'b0, 1'b1, 1'b0);
        end
        @(negedge clock);
        st2("w2_done", 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        st2("w2_ready", 1'b1, 1'b0, 1'b0);

        @(negedge clock);
        check("a_bits_left", 32'(qa.size()), 32'd0);
        check("b_bits_left", 32'(qb.size()), 32'd0);
        check("c_bits_left", 32'(qc.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
